// File: rtl/onchip_ram_avmm_pipe.sv
// Single-port on-chip RAM behind an Avalon-MM slave with pipelined reads (latency 1 or 2),
// clken back-pressure and an optional post-reset zero-clear sequence.
module onchip_ram_avmm_pipe #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter string       INIT_FILE      = ""
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic [ADDR_W-1:0]   address_i,
  input  logic                chipselect_i,
  input  logic                read_i,
  input  logic                write_i,
  input  logic [DATA_W/8-1:0] byteenable_i,
  input  logic [DATA_W-1:0]   writedata_i,
  input  logic                clken_i,
  output logic                waitrequest_o,
  output logic [DATA_W-1:0]   readdata_o,
  output logic                readdatavalid_o,
  output logic                init_done_o
);

  localparam int unsigned NumBytes = DATA_W / 8;
  localparam int unsigned Depth    = 2 ** ADDR_W;

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_addr_q;
  logic                init_done_q;

  logic [DATA_W-1:0]   mem_q [Depth];

  logic                ready;
  logic                req;
  logic                accept;
  logic                wr_accept;
  logic                rd_accept;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [NumBytes-1:0] mem_be;
  logic [DATA_W-1:0]   mem_wdata;

  logic                v1_q;
  logic [DATA_W-1:0]   d1_q;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;

  // Host handshake
  assign ready         = (state_q == StReady);
  assign waitrequest_o = ~reset_ni | ~ready | ~clken_i;
  assign req           = chipselect_i & (read_i | write_i);
  assign accept        = req & ~waitrequest_o;
  assign wr_accept     = accept & write_i;
  // A simultaneous write wins; the read half is dropped.
  assign rd_accept     = accept & read_i & ~write_i;

  // Write port: the clear sequencer owns the array until it reaches READY.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = address_i;
    mem_be    = byteenable_i;
    mem_wdata = writedata_i;
    if (!ready) begin
      mem_we    = reset_ni;
      mem_addr  = clr_addr_q;
      mem_be    = '1;
      mem_wdata = '0;
    end else begin
      mem_we    = wr_accept;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < NumBytes; b++) begin
        if (mem_be[b]) begin
          mem_q[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  // Preloading from an image is handled by the target's memory-initialisation flow;
  // with the clear enabled the image is overwritten after every reset anyway.
  if (INIT_FILE != "") begin : g_init_image
  end

  // Clear sequencer; clken is deliberately ignored so the clear always advances.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= CLEAR_ON_RESET ? StClear : StReady;
      clr_addr_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (&clr_addr_q) begin
            state_q     <= StReady;
            init_done_q <= 1'b1;
          end
        end
        StReady: begin
          init_done_q <= 1'b1;
        end
      endcase
    end
  end

  assign init_done_o = init_done_q;

  // Read stage 1: array output register. All stages hold while clken is low.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      v1_q <= 1'b0;
      d1_q <= '0;
    end else if (clken_i) begin
      v1_q <= rd_accept;
      if (rd_accept) begin
        d1_q <= mem_q[address_i];
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic              v2_q;
    logic [DATA_W-1:0] d2_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else if (clken_i) begin
        v2_q <= v1_q;
        if (v1_q) begin
          d2_q <= d1_q;
        end
      end
    end

    assign out_valid = v2_q;
    assign out_data  = d2_q;
  end else begin : g_lat1
    assign out_valid = v1_q;
    assign out_data  = d1_q;
  end

  // A held result is only presented once the stall lifts.
  assign readdatavalid_o = out_valid & clken_i;
  assign readdata_o      = out_data;

endmodule

// File: tb/tb_onchip_ram_avmm_pipe.sv
// Directed bench: one latency-1 and one latency-2 RAM (16 words) driven in lockstep.
module tb_onchip_ram_avmm_pipe;

  logic        clk;
  logic        reset_n;
  logic [3:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        clken;

  logic        wait1, wait2;
  logic [31:0] rdata1, rdata2;
  logic        rvalid1, rvalid2;
  logic        done1, done2;

  int n_cmp = 0;
  int n_bad = 0;

  onchip_ram_avmm_pipe #(
    .DATA_W(32), .ADDR_W(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1), .INIT_FILE("")
  ) dut_l1 (
    .clk_i(clk), .reset_ni(reset_n), .address_i(address), .chipselect_i(chipselect),
    .read_i(read), .write_i(write), .byteenable_i(byteenable), .writedata_i(writedata),
    .clken_i(clken), .waitrequest_o(wait1), .readdata_o(rdata1),
    .readdatavalid_o(rvalid1), .init_done_o(done1)
  );

  onchip_ram_avmm_pipe #(
    .DATA_W(32), .ADDR_W(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1), .INIT_FILE("")
  ) dut_l2 (
    .clk_i(clk), .reset_ni(reset_n), .address_i(address), .chipselect_i(chipselect),
    .read_i(read), .write_i(write), .byteenable_i(byteenable), .writedata_i(writedata),
    .clken_i(clken), .waitrequest_o(wait2), .readdata_o(rdata2),
    .readdatavalid_o(rvalid2), .init_done_o(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cs;
    logic        rd;
    logic        wr;
    logic [3:0]  addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        ev1;
    logic [31:0] ed1;
    logic        ev2;
    logic [31:0] ed2;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive on the falling edge, sample 1 ns later.
  task automatic cyc(input logic cs, input logic rd, input logic wr, input logic [3:0] a,
                     input logic [3:0] be, input logic [31:0] wd, input logic ck);
    @(negedge clk);
    chipselect = cs;
    read       = rd;
    write      = wr;
    address    = a;
    byteenable = be;
    writedata  = wd;
    clken      = ck;
    #1;
  endtask

  task automatic chk_valids(input string tag, input logic ev1, input logic [31:0] ed1,
                            input logic ev2, input logic [31:0] ed2);
    chk({tag, " l1 valid"}, {31'd0, rvalid1}, {31'd0, ev1});
    if (ev1) chk({tag, " l1 data"}, rdata1, ed1);
    chk({tag, " l2 valid"}, {31'd0, rvalid2}, {31'd0, ev2});
    if (ev2) chk({tag, " l2 data"}, rdata2, ed2);
  endtask

  // Release reset and walk the 16-cycle clear, poking the bus while it runs.
  task automatic run_clear(input string tag);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      reset_n    = 1'b1;
      chipselect = (c == 13) || (c == 15);
      read       = (c == 13);
      write      = (c == 15);
      address    = 4'd0;
      byteenable = 4'hF;
      writedata  = 32'hDEAD_BEEF;
      clken      = (c % 2 == 1);
      #1;
      chk($sformatf("%s c%0d l1 wait", tag, c), {31'd0, wait1}, 32'd1);
      chk($sformatf("%s c%0d l2 wait", tag, c), {31'd0, wait2}, 32'd1);
      chk($sformatf("%s c%0d l1 done", tag, c), {31'd0, done1}, 32'd0);
      chk($sformatf("%s c%0d l2 done", tag, c), {31'd0, done2}, 32'd0);
      chk_valids($sformatf("%s c%0d", tag, c), 1'b0, 32'd0, 1'b0, 32'd0);
    end
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'hF, 32'd0, 1'b1);
    chk({tag, " end l1 done"}, {31'd0, done1}, 32'd1);
    chk({tag, " end l2 done"}, {31'd0, done2}, 32'd1);
    chk({tag, " end l1 wait"}, {31'd0, wait1}, 32'd0);
    chk({tag, " end l2 wait"}, {31'd0, wait2}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " l1 wait"}, {31'd0, wait1}, 32'd1);
    chk({tag, " l2 wait"}, {31'd0, wait2}, 32'd1);
    chk({tag, " l1 rdata"}, rdata1, 32'd0);
    chk({tag, " l2 rdata"}, rdata2, 32'd0);
    chk({tag, " l1 done"}, {31'd0, done1}, 32'd0);
    chk({tag, " l2 done"}, {31'd0, done2}, 32'd0);
    chk_valids(tag, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    //          cs    rd    wr    addr  be    wdata          ev1   ed1            ev2   ed2
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'd0, 4'hF, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 4'd5, 4'hF, 32'h11223344,  1'b1, 32'h0,         1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 4'd5, 4'h5, 32'hAABBCCDD,  1'b0, 32'h0,         1'b1, 32'h0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 4'd5, 4'hF, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 4'd1, 4'hF, 32'h00000101,  1'b1, 32'h11BB33DD,  1'b0, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 4'd2, 4'hF, 32'h00000202,  1'b0, 32'h0,         1'b1, 32'h11BB33DD};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 4'd3, 4'hF, 32'h00000303,  1'b0, 32'h0,         1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 4'd1, 4'hF, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'd2, 4'hF, 32'h0,         1'b1, 32'h00000101,  1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 4'd3, 4'hF, 32'h0,         1'b1, 32'h00000202,  1'b1, 32'h00000101};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 4'd0, 4'hF, 32'h0,         1'b1, 32'h00000303,  1'b1, 32'h00000202};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 4'd0, 4'hF, 32'h0,         1'b0, 32'h0,         1'b1, 32'h00000303};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 4'd7, 4'hF, 32'hCAFE0001,  1'b0, 32'h0,         1'b0, 32'h0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 4'd7, 4'hF, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 4'd6, 4'h0, 32'hFFFFFFFF,  1'b1, 32'hCAFE0001,  1'b0, 32'h0};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 4'd6, 4'hF, 32'h0,         1'b0, 32'h0,         1'b1, 32'hCAFE0001};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 4'd5, 4'hF, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 4'd0, 4'hF, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 4'd0, 4'hF, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};

    reset_n    = 1'b0;
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    address    = 4'd0;
    byteenable = 4'hF;
    writedata  = 32'd0;
    clken      = 1'b1;

    @(negedge clk);
    @(negedge clk);
    #1;
    chk_reset_vals("reset");

    run_clear("clear0");

    for (int i = 0; i < 19; i++) begin
      cyc(vecs[i].cs, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd, 1'b1);
      chk($sformatf("vec%0d l1 wait", i), {31'd0, wait1}, 32'd0);
      chk_valids($sformatf("vec%0d", i), vecs[i].ev1, vecs[i].ed1, vecs[i].ev2, vecs[i].ed2);
    end

    // Stall straight after a read accept; requests during the stall must not be taken.
    cyc(1'b1, 1'b1, 1'b0, 4'd5, 4'hF, 32'd0, 1'b1);
    for (int s = 0; s < 3; s++) begin
      cyc(1'b1, 1'b1, 1'b0, 4'd2, 4'hF, 32'd0, 1'b0);
      chk($sformatf("stall%0d l1 wait", s), {31'd0, wait1}, 32'd1);
      chk($sformatf("stall%0d l2 wait", s), {31'd0, wait2}, 32'd1);
      chk_valids($sformatf("stall%0d", s), 1'b0, 32'd0, 1'b0, 32'd0);
    end
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'hF, 32'd0, 1'b1);
    chk_valids("unstall0", 1'b1, 32'h11BB33DD, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'hF, 32'd0, 1'b1);
    chk_valids("unstall1", 1'b0, 32'd0, 1'b1, 32'h11BB33DD);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 4'hF, 32'd0, 1'b1);
    chk_valids("unstall2", 1'b0, 32'd0, 1'b0, 32'd0);

    // Fill every word, then reset with two reads in flight.
    for (int a = 0; a < 16; a++) begin
      cyc(1'b1, 1'b0, 1'b1, 4'(a), 4'hF, 32'hA5A5_0000 | 32'(a), 1'b1);
    end
    cyc(1'b1, 1'b1, 1'b0, 4'd1, 4'hF, 32'd0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 4'd2, 4'hF, 32'd0, 1'b1);
    @(negedge clk);
    reset_n    = 1'b0;
    chipselect = 1'b0;
    read       = 1'b0;
    #1;
    chk_reset_vals("midrst0");
    @(negedge clk);
    #1;
    chk_reset_vals("midrst1");

    run_clear("clear1");

    // Back-to-back sweep: every word must read back as zero, one valid per cycle.
    for (int i = 0; i < 18; i++) begin
      cyc(1'b1, (i < 16), 1'b0, 4'(i), 4'hF, 32'd0, 1'b1);
      chk_valids($sformatf("sweep%0d", i), (i >= 1 && i <= 16), 32'd0,
                 (i >= 2 && i <= 17), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
